// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HOLD/HALT sequencer with branch redirect.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        STALL,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  output logic        ALIGN_ERR
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic        instr_valid_reg, instr_valid_next;
  logic [31:0] br_target_aligned;
  logic        misaligned;

  assign br_target_aligned = BR_TARGET & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_reg, align_err_next;
  assign misaligned = |BR_TARGET[1:0];
  assign ALIGN_ERR  = align_err_reg;
`else
  assign misaligned = 1'b0;
  assign ALIGN_ERR  = 1'b0;
`endif

  // State register and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      instr_pc_reg    <= 32'h0;
      instr_valid_reg <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err_reg   <= align_err_next;
`endif
    end
  end

  // Next-state logic; a redirect outranks both a memory response and a stall
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;
`ifdef FETCH_ALIGN_CHECK_EN
    align_err_next   = align_err_reg;
`endif
    if (state_reg == HALT) begin
      instr_valid_next = 1'b0;
    end else if (BR_TAKEN) begin
      instr_valid_next = 1'b0;
      if (misaligned) begin
        state_next = HALT;
`ifdef FETCH_ALIGN_CHECK_EN
        align_err_next = 1'b1;
`endif
      end else begin
        pc_next    = br_target_aligned;
        state_next = FETCH;
      end
    end else begin
      case (state_reg)
        IDLE: state_next = FETCH;
        FETCH: begin
          if (IMEM_ACK) begin
            instr_next       = IMEM_RDATA;
            instr_pc_next    = pc_reg;
            instr_valid_next = 1'b1;
            pc_next          = pc_reg + 32'd4;
            state_next       = HOLD;
          end
        end
        HOLD: begin
          if (!STALL) begin
            instr_valid_next = 1'b0;
            state_next       = FETCH;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    IMEM_REQ    = (state_reg == FETCH);
    IMEM_ADDR   = pc_reg;
    INSTR       = instr_reg;
    INSTR_PC    = instr_pc_reg;
    INSTR_VALID = instr_valid_reg;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit, plus a reset-mid-fetch sequence.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        BR_TAKEN = 1'b0;
  logic [31:0] BR_TARGET = 32'h0;
  logic        STALL = 1'b0;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_VALID;
  logic        ALIGN_ERR;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit AEN = 1'b1;
`else
  localparam bit AEN = 1'b0;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .STALL(STALL), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .INSTR_VALID(INSTR_VALID), .ALIGN_ERR(ALIGN_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        aerr;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_checks = 0;
  int   miscompares = 0;

  task automatic add(input logic ack, input logic [31:0] rdata, input logic br,
                     input logic [31:0] tgt, input logic stall, input logic req,
                     input logic [31:0] addr, input logic valid,
                     input logic [31:0] instr, input logic [31:0] ipc,
                     input logic aerr);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.br = br; v.tgt = tgt; v.stall = stall;
    v.req = req; v.addr = addr; v.valid = valid; v.instr = instr;
    v.ipc = ipc; v.aerr = aerr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                          input logic valid, input logic [31:0] instr,
                          input logic [31:0] ipc, input logic aerr);
    chk({tag, ".req"},   {31'h0, IMEM_REQ},    {31'h0, req});
    chk({tag, ".addr"},  IMEM_ADDR,            addr);
    chk({tag, ".valid"}, {31'h0, INSTR_VALID}, {31'h0, valid});
    chk({tag, ".instr"}, INSTR,                instr);
    chk({tag, ".ipc"},   INSTR_PC,             ipc);
    chk({tag, ".aerr"},  {31'h0, ALIGN_ERR},   {31'h0, aerr});
    n_vec++;
  endtask

  initial begin
    // ack rdata br tgt stall | req addr valid instr ipc aerr
    add(1, 32'hAAAA_0000, 0, 0, 0,  0, 32'h0,  0, 32'h0, 32'h0, 0);            // IDLE, ack ignored
    add(1, 32'h1111_0000, 0, 0, 0,  1, 32'h0,  0, 32'h0, 32'h0, 0);
    add(1, 32'hBAD0_0000, 0, 0, 0,  0, 32'h4,  1, 32'h1111_0000, 32'h0, 0);
    add(1, 32'h2222_0004, 0, 0, 0,  1, 32'h4,  0, 32'h1111_0000, 32'h0, 0);
    add(1, 32'hBAD0_0000, 0, 0, 0,  0, 32'h8,  1, 32'h2222_0004, 32'h4, 0);
    add(1, 32'h3333_0008, 0, 0, 0,  1, 32'h8,  0, 32'h2222_0004, 32'h4, 0);
    add(1, 32'hBAD0_0000, 0, 0, 0,  0, 32'hC,  1, 32'h3333_0008, 32'h8, 0);
    add(1, 32'h4444_000C, 0, 0, 0,  1, 32'hC,  0, 32'h3333_0008, 32'h8, 0);
    add(1, 32'hBAD0_0000, 0, 0, 0,  0, 32'h10, 1, 32'h4444_000C, 32'hC, 0);
    // ack delayed three cycles
    for (int i = 0; i < 3; i++)
      add(0, 32'hBAD0_0000, 0, 0, 0, 1, 32'h10, 0, 32'h4444_000C, 32'hC, 0);
    add(1, 32'h5555_0010, 0, 0, 0,  1, 32'h10, 0, 32'h4444_000C, 32'hC, 0);
    // five stalled cycles in HOLD with a spurious ack present
    for (int i = 0; i < 5; i++)
      add(1, 32'hBAD0_0000, 0, 0, 1, 0, 32'h14, 1, 32'h5555_0010, 32'h10, 0);
    add(0, 32'h0, 0, 0, 0,  0, 32'h14, 1, 32'h5555_0010, 32'h10, 0);
    // redirect coincident with ack: response discarded
    add(1, 32'hDEAD_BEEF, 1, 32'h100, 0,  1, 32'h14, 0, 32'h5555_0010, 32'h10, 0);
    add(0, 32'h0, 0, 0, 0,  1, 32'h100, 0, 32'h5555_0010, 32'h10, 0);
    add(1, 32'h6666_0100, 0, 0, 0,  1, 32'h100, 0, 32'h5555_0010, 32'h10, 0);
    // redirect in HOLD while stalled flushes valid
    add(0, 32'h0, 1, 32'h200, 1,  0, 32'h104, 1, 32'h6666_0100, 32'h100, 0);
    add(0, 32'h0, 1, 32'hFFFF_FFFC, 0,  1, 32'h200, 0, 32'h6666_0100, 32'h100, 0);
    add(1, 32'h7777_FFFC, 0, 0, 0,  1, 32'hFFFF_FFFC, 0, 32'h6666_0100, 32'h100, 0);
    add(0, 32'h0, 0, 0, 0,  0, 32'h0, 1, 32'h7777_FFFC, 32'hFFFF_FFFC, 0);
    // misaligned redirect
    add(0, 32'h0, 1, 32'h102, 0,  1, 32'h0, 0, 32'h7777_FFFC, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 2; i++)
      add(0, 32'h0, 0, 0, 0, !AEN, AEN ? 32'h0 : 32'h100, 0,
          32'h7777_FFFC, 32'hFFFF_FFFC, AEN);

    // Reset state
    repeat (2) @(negedge CLK);
    chk_outs("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    RST_N = 1'b1;

    foreach (vq[i]) begin
      chk_outs($sformatf("vec%0d", i), vq[i].req, vq[i].addr, vq[i].valid,
               vq[i].instr, vq[i].ipc, vq[i].aerr);
      $display("vec %0d: req=%b addr=%h valid=%b instr=%h pc=%h aerr=%b",
               i, IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR, INSTR_PC, ALIGN_ERR);
      IMEM_ACK = vq[i].ack; IMEM_RDATA = vq[i].rdata; BR_TAKEN = vq[i].br;
      BR_TARGET = vq[i].tgt; STALL = vq[i].stall;
      @(negedge CLK);
    end

    // Asynchronous reset in the middle of a cycle, then a late ack in IDLE
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hBAD0_0001; BR_TAKEN = 1'b0; STALL = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk_outs("async_rst", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    $display("async reset: req=%b addr=%h valid=%b", IMEM_REQ, IMEM_ADDR, INSTR_VALID);
    @(negedge CLK);
    RST_N = 1'b1;
    chk_outs("idle", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge CLK);
    chk_outs("refetch", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    IMEM_RDATA = 32'h1234_5678;
    @(negedge CLK);
    chk_outs("refetch_hold", 0, 32'h4, 1, 32'h1234_5678, 32'h0, 0);
    $display("after reset: instr=%h pc=%h valid=%b", INSTR, INSTR_PC, INSTR_VALID);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
